l2_backing_mem: RTL and testbench
=================================

Name: l2_backing_mem

Overview:
- Behavioural main-memory model for the data L2's external port; sits directly downstream of the system top.
- Accepts block-granular read (refill) and write (write-back) requests.
- Read data is returned as a burst of indexed subblocks after a fixed access latency.
- Write data is absorbed as a burst of indexed subblocks, then completion is signalled.

Parameters:
- ADDR_BITS, 32, byte-address width (matches DADDR_bits).
- SUBBLOCKS_LOG2, 2, log2 of beats per L2 block.
- SUB_W, 128, beat width in bits (L2 block / SUBBLOCKS).
- DEPTH_LOG2, 12, log2 of number of blocks stored.
- RD_LAT, 8, cycles from accept to first read beat (>=1).
- WR_LAT, 4, cycles from last write beat to completion pulse (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  ADDR_BITS  request byte address; block offset bits ignored.
- en  in  1  request valid; held until accR/accW seen.
- we  in  1  1 = write-back, 0 = refill; sampled with en.
- wstrobe  in  SUBBLOCKS_LOG2  beat index of wdata.
- wdata  in  SUB_W  write beat data.
- rstrobe  out  SUBBLOCKS_LOG2  beat index of rdata.
- rdata  out  SUB_W  read beat data.
- ready  out  1  read: beat valid; write: completion pulse.
- accR  out  1  one-cycle read-accept pulse.
- accW  out  1  one-cycle write-accept pulse.

Behaviour:
- Reset (reset=0, async): state IDLE; ready, accR, accW, rstrobe, rdata all 0; counters 0. Array contents are not reset.
- Block index: addr[ADDR_BITS-1 : log2(SUB_W/8)+SUBBLOCKS_LOG2], truncated to DEPTH_LOG2 LSBs (wraps/aliases). Entry address is {index, beat}.
- IDLE:
  - en=1, we=0: latch index, pulse accR next cycle, go to R_WAIT.
  - en=1, we=1: latch index, pulse accW next cycle, go to W_BEAT.
  - en is ignored in every other state, so a request held into the accept cycle is not re-accepted.
- R_WAIT: count RD_LAT cycles from the accept edge, then go to R_BURST.
- R_BURST:
  - Registered outputs for SUBBLOCKS consecutive cycles: ready=1, rstrobe = 0,1,...,SUBBLOCKS-1 in order, rdata = mem[{index, rstrobe}].
  - After the beat with rstrobe = SUBBLOCKS-1, ready drops to 0 and state returns to IDLE.
  - No back-pressure.
- W_BEAT:
  - Starts the cycle after accW.
  - Each of SUBBLOCKS consecutive cycles writes wdata into mem[{index, wstrobe}].
  - Beat order is free; a repeated index overwrites (last wins).
  - After SUBBLOCKS beats, go to W_WAIT.
- W_WAIT: after WR_LAT cycles, ready=1 for exactly one cycle, then IDLE.
- Read-after-write to the same block returns the written data; write beats commit before ready pulses.
- Earliest next accept is the cycle after return to IDLE; en held high there starts a new request.
- Reset mid-operation aborts immediately to IDLE with outputs cleared. Write beats already captured remain in the array.

Optional Feature:
- L2_BACKING_MEM_STATS_EN
- Defined:
  - Adds outputs rd_count [31:0] and wr_count [31:0], incremented on each accR/accW pulse, saturating at 0xFFFFFFFF, cleared by reset.
  - Adds busy_cycles [31:0]: count of non-IDLE cycles, wrapping.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then read addr=0x40, RD_LAT=8 -> accR at cycle 1; beats 0..3 with ready=1 at cycles 10-13; rdata=X.
- Write addr=0x1000, wdata beats 0xA0..0xA3 in order 0,1,2,3 -> accW cycle 1; ready pulse 4 cycles after last beat. Then read 0x1000 -> rdata 0xA0,0xA1,0xA2,0xA3 with rstrobe 0..3.
- Write with wstrobe order 3,1,0,2 -> readback is by index; wstrobe 2,2,0,1 -> entry 2 holds the second beat, entry 3 unchanged.
- en held high through accR and the full burst -> exactly one accR; second accR the cycle after IDLE returns.
- Aliasing: write 0x10 vs addr 0x10 + (1<<(DEPTH_LOG2+6)) -> read of either returns the same data.
- Assert reset during R_BURST beat 1 -> ready/rstrobe 0 immediately; fresh read afterwards gives correct full burst. With STATS_EN, rd_count=1 after the first test and 0 after reset.

Source files
------------

// File: rtl/l2_backing_mem.sv
// l2_backing_mem: block-granular main-memory model behind the data L2 (burst refill / write-back).
// Define L2_BACKING_MEM_STATS_EN to add rd_count, wr_count and busy_cycles outputs.
module l2_backing_mem #(
  parameter int ADDR_BITS      = 32,
  parameter int SUBBLOCKS_LOG2 = 2,
  parameter int SUB_W          = 128,
  parameter int DEPTH_LOG2     = 12,
  parameter int RD_LAT         = 8,
  parameter int WR_LAT         = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_BITS-1:0]      addr,
  input  logic                      en,
  input  logic                      we,
  input  logic [SUBBLOCKS_LOG2-1:0] wstrobe,
  input  logic [SUB_W-1:0]          wdata,
  output logic [SUBBLOCKS_LOG2-1:0] rstrobe,
  output logic [SUB_W-1:0]          rdata,
  output logic                      ready,
  output logic                      accR,
  output logic                      accW
`ifdef L2_BACKING_MEM_STATS_EN
  ,
  output logic [31:0]               rd_count,
  output logic [31:0]               wr_count,
  output logic [31:0]               busy_cycles
`endif
);
  localparam int OFF_BITS = $clog2(SUB_W / 8) + SUBBLOCKS_LOG2;
  localparam int ENT_BITS = DEPTH_LOG2 + SUBBLOCKS_LOG2;
  localparam int CNT_W    = 16;
  localparam logic [SUBBLOCKS_LOG2-1:0] LAST_BEAT = SUBBLOCKS_LOG2'((1 << SUBBLOCKS_LOG2) - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_R_WAIT  = 3'd1;
  localparam logic [2:0] S_R_BURST = 3'd2;
  localparam logic [2:0] S_W_BEAT  = 3'd3;
  localparam logic [2:0] S_W_WAIT  = 3'd4;

  logic [2:0]                state_q, state_d;
  logic [DEPTH_LOG2-1:0]     idx_q, idx_d;
  logic [SUBBLOCKS_LOG2-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      ready_q, ready_d;
  logic                      acc_r_q, acc_r_d;
  logic                      acc_w_q, acc_w_d;
  logic [SUBBLOCKS_LOG2-1:0] rstrobe_q, rstrobe_d;
  logic [SUB_W-1:0]          rdata_q, rdata_d;
  logic                      mem_we;
  logic [SUB_W-1:0]          mem [1 << ENT_BITS];

  // Offset bits above the index are deliberately ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^addr;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    acc_r_d   = 1'b0;
    acc_w_d   = 1'b0;
    rstrobe_d = '0;
    rdata_d   = '0;
    mem_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          idx_d  = addr[OFF_BITS +: DEPTH_LOG2];
          cnt_d  = '0;
          beat_d = '0;
          if (we) begin
            acc_w_d = 1'b1;
            state_d = S_W_BEAT;
          end else begin
            acc_r_d = 1'b1;
            state_d = S_R_WAIT;
          end
        end
      end
      S_R_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(RD_LAT - 1)) state_d = S_R_BURST;
      end
      S_R_BURST: begin
        ready_d   = 1'b1;
        rstrobe_d = beat_q;
        rdata_d   = mem[{idx_q, beat_q}];
        beat_d    = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) state_d = S_IDLE;
      end
      S_W_BEAT: begin
        // The accW cycle itself carries no data; beats begin one cycle later.
        if (!acc_w_q) begin
          mem_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = S_W_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_W_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q >= CNT_W'(WR_LAT - 1)) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      beat_q    <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      acc_r_q   <= 1'b0;
      acc_w_q   <= 1'b0;
      rstrobe_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      acc_r_q   <= acc_r_d;
      acc_w_q   <= acc_w_d;
      rstrobe_q <= rstrobe_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[{idx_q, wstrobe}] <= wdata;
  end

  assign rstrobe = rstrobe_q;
  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign accR    = acc_r_q;
  assign accW    = acc_w_q;

`ifdef L2_BACKING_MEM_STATS_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;
  logic [31:0] busy_q, busy_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    rd_count_d = acc_r_d ? sat_inc(rd_count_q) : rd_count_q;
    wr_count_d = acc_w_d ? sat_inc(wr_count_q) : wr_count_q;
    busy_d     = (state_q != S_IDLE) ? busy_q + 32'd1 : busy_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
      busy_q     <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      busy_q     <= busy_d;
    end
  end

  assign rd_count    = rd_count_q;
  assign wr_count    = wr_count_q;
  assign busy_cycles = busy_q;
`endif
endmodule

// File: tb/tb_l2_backing_mem.sv
// Directed bench for l2_backing_mem: burst timing, write ordering, aliasing, hold-off and reset abort.
module tb_l2_backing_mem;
  localparam int RD_LAT = 8;
  localparam int WR_LAT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  addr;
  logic         en;
  logic         we;
  logic [1:0]   wstrobe;
  logic [127:0] wdata;
  logic [1:0]   rstrobe;
  logic [127:0] rdata;
  logic         ready;
  logic         accR;
  logic         accW;
`ifdef L2_BACKING_MEM_STATS_EN
  logic [31:0]  rd_count, wr_count, busy_cycles;
`endif

  l2_backing_mem #(
    .ADDR_BITS(32), .SUBBLOCKS_LOG2(2), .SUB_W(128), .DEPTH_LOG2(12),
    .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .en(en), .we(we),
    .wstrobe(wstrobe), .wdata(wdata), .rstrobe(rstrobe), .rdata(rdata),
    .ready(ready), .accR(accR), .accW(accW)
`ifdef L2_BACKING_MEM_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count), .busy_cycles(busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   beat;
    logic [127:0] data;
    bit           known;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_block(input logic [3:0][127:0] d, input bit known);
    exp_t e;
    for (int b = 0; b < 4; b++) begin
      e.beat  = 2'(b);
      e.data  = d[b];
      e.known = known;
      sb_q.push_back(e);
    end
  endtask

  // Starts in the accept cycle; returns in the cycle just after the last beat.
  task automatic collect_read(input string tag, output int extra_acc);
    int   lat;
    exp_t e;
    extra_acc = 0;
    lat = 0;
    do begin
      tick();
      lat++;
      if (accR) extra_acc++;
    end while (!ready && lat < 40);
    chk({tag, "_lat"}, 128'(lat), 128'(RD_LAT + 1));
    for (int b = 0; b < 4; b++) begin
      chk({tag, "_sb_nonempty"}, 128'(sb_q.size() > 0), 128'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({tag, "_ready"}, 128'(ready), 128'd1);
        chk({tag, "_rstrobe"}, 128'(rstrobe), 128'(e.beat));
        if (e.known) chk({tag, "_rdata"}, rdata, e.data);
      end
      tick();
      if (b < 3 && accR) extra_acc++;
    end
    chk({tag, "_ready_drop"}, 128'(ready), 128'd0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a,
                         input logic [3:0][127:0] d, input bit known);
    int extra;
    en = 1'b1; we = 1'b0; addr = a;
    tick();
    chk({tag, "_accR"}, 128'(accR), 128'd1);
    en = 1'b0;
    push_block(d, known);
    collect_read(tag, extra);
    chk({tag, "_no_reaccept"}, 128'(extra), 128'd0);
  endtask

  task automatic do_write(input string tag, input logic [31:0] a,
                          input logic [3:0][1:0] strb, input logic [3:0][127:0] d);
    int lat;
    en = 1'b1; we = 1'b1; addr = a;
    tick();
    chk({tag, "_accW"}, 128'(accW), 128'd1);
    en = 1'b0; we = 1'b0;
    for (int b = 0; b < 4; b++) begin
      tick();
      if (b == 0) chk({tag, "_accW_pulse"}, 128'(accW), 128'd0);
      wstrobe = strb[b];
      wdata   = d[b];
    end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!ready && lat < 20);
    chk({tag, "_wr_lat"}, 128'(lat), 128'(WR_LAT));
    tick();
    chk({tag, "_wr_ready_pulse"}, 128'(ready), 128'd0);
  endtask

  initial begin
    logic [3:0][127:0] da, db, dc, dd, dz;
    logic [3:0][1:0]   s_in, s_scr, s_rep;
    int extra, lat;
    exp_t e;

    for (int b = 0; b < 4; b++) begin
      da[b] = 128'(32'hA0 + b);
      db[b] = 128'(32'hB0 + b);
      dd[b] = {32'hDEAD_0000 + 32'(b), 96'h1234_5678_9ABC_DEF0_0F0F_0F0F};
      dz[b] = '0;
    end
    s_in  = {2'd3, 2'd2, 2'd1, 2'd0};
    s_scr = {2'd2, 2'd0, 2'd1, 2'd3};
    s_rep = {2'd1, 2'd0, 2'd2, 2'd2};
    dc    = {128'hC3, 128'hC2, 128'hC1, 128'hC0};

    reset = 1'b0; en = 1'b0; we = 1'b0; addr = '0; wstrobe = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", 128'(ready), 128'd0);
    chk("rst_accR", 128'(accR), 128'd0);
    chk("rst_accW", 128'(accW), 128'd0);
    chk("rst_rstrobe", 128'(rstrobe), 128'd0);
    chk("rst_rdata", rdata, 128'd0);
    reset = 1'b1;
    tick();

    do_read("rd_uninit", 32'h40, dz, 1'b0);
`ifdef L2_BACKING_MEM_STATS_EN
    chk("stats_rd_count_1", 128'(rd_count), 128'd1);
`endif

    do_write("wr_inorder", 32'h1000, s_in, da);
    do_read("rd_inorder", 32'h1000, da, 1'b1);

    do_write("wr_scrambled", 32'h2000, s_scr, {db[2], db[0], db[1], db[3]});
    do_read("rd_scrambled", 32'h2000, db, 1'b1);

    do_write("wr_repeat", 32'h2000, s_rep, dc);
    do_read("rd_repeat", 32'h2000, {db[3], dc[1], dc[3], dc[2]}, 1'b1);

    // en held high across the whole first burst
    en = 1'b1; we = 1'b0; addr = 32'h1000;
    tick();
    chk("hold_accR_first", 128'(accR), 128'd1);
    push_block(da, 1'b1);
    collect_read("hold_burst1", extra);
    chk("hold_single_accept", 128'(extra), 128'd0);
    chk("hold_accR_second", 128'(accR), 128'd1);
    en = 1'b0;
    push_block(da, 1'b1);
    collect_read("hold_burst2", extra);

    do_write("wr_alias", 32'h10 + (32'd1 << 18), s_in, dd);
    do_read("rd_alias_low", 32'h10, dd, 1'b1);
    do_read("rd_alias_high", 32'h10 + (32'd1 << 18), dd, 1'b1);

    // reset asserted while beat 1 is on the outputs
    en = 1'b1; we = 1'b0; addr = 32'h1000;
    tick();
    chk("abort_accR", 128'(accR), 128'd1);
    en = 1'b0;
    push_block(da, 1'b1);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!ready && lat < 40);
    chk("abort_lat", 128'(lat), 128'(RD_LAT + 1));
    e = sb_q.pop_front();
    chk("abort_beat0_rdata", rdata, e.data);
    tick();
    chk("abort_beat1_rstrobe", 128'(rstrobe), 128'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_ready", 128'(ready), 128'd0);
    chk("abort_rstrobe", 128'(rstrobe), 128'd0);
    chk("abort_rdata", rdata, 128'd0);
    sb_q.delete();
    #2 reset = 1'b1;
    tick();
`ifdef L2_BACKING_MEM_STATS_EN
    chk("stats_rd_count_rst", 128'(rd_count), 128'd0);
`endif
    chk("post_abort_idle_ready", 128'(ready), 128'd0);
    do_read("rd_after_abort", 32'h1000, da, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
